// File: rtl/alu_issue.sv
// Decode-and-issue sequencer for the single-cycle RV32I ALU: one instruction in flight,
// IDLE -> ISSUE -> WB. Optional LUI support is enabled by defining ALU_ISSUE_LUI_EN.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [6:0]  funct7,
  output logic [2:0]  funct3_adder,
  output logic [2:0]  funct3_comp,
  input  logic [31:0] adder_rsv,
  input  logic [31:0] shifter_rsv,
  input  logic [31:0] comparator_rsv,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        illegal
);

  // state | meaning
  // IDLE  | ready for a new instruction
  // ISSUE | operands on the ALU bus, result captured at end of cycle
  // WB    | write-back strobe (suppressed for rd==x0)
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  state_t      r_state, w_state_nxt;
  logic        r_rst_done;
  logic [31:0] r_op1, r_op2, r_rd_wdata;
  logic [6:0]  r_funct7;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd_addr;
  logic        r_illegal;

  logic [6:0]  w_opcode, w_f7, w_f7_dec;
  logic [2:0]  w_f3, w_f3_dec;
  logic [31:0] w_op1, w_op2, w_result;
  logic        w_legal, w_hs;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign w_hs     = instr_valid && instr_ready;

  always_comb begin
    w_legal  = 1'b0;
    w_op1    = rs1_data;
    w_op2    = rs2_data;
    w_f7_dec = w_f7;
    w_f3_dec = w_f3;
    case (w_opcode)
      OPC_OP: begin
        w_legal = (w_f7 == 7'b0) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
          w_op2   = {27'b0, instr[24:20]};
          w_legal = (w_f7 == 7'b0) || ((w_f3 == 3'b101) && (w_f7 == F7_ALT));
        end else begin
          // immediate bits [31:25] are not a funct7; keep addi from subtracting
          w_op2    = {{20{instr[31]}}, instr[31:20]};
          w_f7_dec = 7'b0;
          w_legal  = 1'b1;
        end
      end
`ifdef ALU_ISSUE_LUI_EN
      OPC_LUI: begin
        w_op1    = 32'b0;
        w_op2    = {instr[31:12], 12'b0};
        w_f3_dec = 3'b000;
        w_f7_dec = 7'b0;
        w_legal  = 1'b1;
      end
`else
      OPC_LUI: w_legal = 1'b0;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (r_funct3)
      3'b001, 3'b101: w_result = shifter_rsv;
      3'b010, 3'b011: w_result = comparator_rsv;
      default:        w_result = adder_rsv;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    rd_we       = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = r_rst_done;
        if (w_hs && w_legal) w_state_nxt = ISSUE;
      end
      ISSUE: w_state_nxt = WB;
      WB: begin
        rd_we       = (r_rd_addr != 5'd0);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_done <= 1'b0;
      r_op1      <= 32'b0;
      r_op2      <= 32'b0;
      r_funct7   <= 7'b0;
      r_funct3   <= 3'b0;
      r_rd_addr  <= 5'b0;
      r_rd_wdata <= 32'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      r_illegal  <= w_hs && !w_legal;
      if (w_hs && w_legal) begin
        r_op1     <= w_op1;
        r_op2     <= w_op2;
        r_funct7  <= w_f7_dec;
        r_funct3  <= w_f3_dec;
        r_rd_addr <= instr[11:7];
      end
      if (r_state == ISSUE) r_rd_wdata <= w_result;
    end
  end

  assign op1          = r_op1;
  assign op2          = r_op2;
  assign funct7       = r_funct7;
  assign funct3_adder = r_funct3;
  assign funct3_comp  = r_funct3;
  assign rd_addr      = r_rd_addr;
  assign rd_wdata     = r_rd_wdata;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU attached to the operand bus.
// Expected LUI behaviour follows ALU_ISSUE_LUI_EN.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] op1, op2;
  logic [6:0]  funct7;
  logic [2:0]  funct3_adder, funct3_comp;
  logic [31:0] adder_rsv, shifter_rsv, comparator_rsv;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .op1(op1), .op2(op2), .funct7(funct7), .funct3_adder(funct3_adder), .funct3_comp(funct3_comp),
    .adder_rsv(adder_rsv), .shifter_rsv(shifter_rsv), .comparator_rsv(comparator_rsv),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // behavioural ALU, combinational from the operand bus
  always_comb begin
    adder_rsv = op1 + op2;
    case (funct3_adder)
      3'b000:  adder_rsv = funct7[5] ? (op1 - op2) : (op1 + op2);
      3'b100:  adder_rsv = op1 ^ op2;
      3'b110:  adder_rsv = op1 | op2;
      3'b111:  adder_rsv = op1 & op2;
      default: adder_rsv = op1 + op2;
    endcase
    shifter_rsv = op1 << op2[4:0];
    if (funct3_adder == 3'b101)
      shifter_rsv = funct7[5] ? 32'($signed(op1) >>> op2[4:0]) : (op1 >> op2[4:0]);
    comparator_rsv = 32'b0;
    if (funct3_comp == 3'b010) comparator_rsv = {31'b0, $signed(op1) < $signed(op2)};
    else if (funct3_comp == 3'b011) comparator_rsv = {31'b0, op1 < op2};
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = 32'b0; instr_valid = 1'b0; rs1_data = 32'b0; rs2_data = 32'b0;
    #3;
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", instr_ready); end
    n_cmp++; if (op1 !== 32'b0) begin n_err++; $display("FAIL rst_op1: got %h want 0", op1); end
    n_cmp++; if (rd_wdata !== 32'b0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", rd_wdata); end
    n_cmp++; if ({rd_we, illegal} !== 2'b00) begin n_err++; $display("FAIL rst_we_ill: got %b want 00", {rd_we, illegal}); end
    step(); step();
    @(negedge clk); rst = 1'b0;
    step();
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", instr_ready); end
  endtask

  task automatic test_add();
    rs1_data = 32'd5; rs2_data = 32'd7;
    @(negedge clk); instr = 32'h002081B3; instr_valid = 1'b1; #1;
    n_cmp++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin n_err++; $display("FAIL add_rsaddr: got %h/%h want 1/2", rs1_addr, rs2_addr); end
    @(posedge clk); #1; instr_valid = 1'b0;
    n_cmp++; if (op1 !== 32'd5 || op2 !== 32'd7) begin n_err++; $display("FAIL add_ops: got %h/%h want 5/7", op1, op2); end
    n_cmp++; if (funct7 !== 7'd0 || funct3_adder !== 3'd0 || funct3_comp !== 3'd0) begin n_err++; $display("FAIL add_funct: got %h/%h/%h want 0/0/0", funct7, funct3_adder, funct3_comp); end
    n_cmp++; if (instr_ready !== 1'b0 || rd_we !== 1'b0) begin n_err++; $display("FAIL add_issue: ready %b we %b want 0 0", instr_ready, rd_we); end
    step();
    n_cmp++; if (rd_we !== 1'b1 || rd_addr !== 5'd3 || rd_wdata !== 32'd12) begin n_err++; $display("FAIL add_wb: we %b rd %0d data %h want 1 3 0000000c", rd_we, rd_addr, rd_wdata); end
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL add_wb_ready: got %b want 0", instr_ready); end
    step();
    n_cmp++; if (rd_we !== 1'b0 || instr_ready !== 1'b1) begin n_err++; $display("FAIL add_done: we %b ready %b want 0 1", rd_we, instr_ready); end
  endtask

  task automatic test_srai();
    rs1_data = 32'h80000000; rs2_data = 32'h00000055;
    send(32'h4040D213);
    n_cmp++; if (op2 !== 32'd4 || funct7 !== 7'b0100000 || funct3_adder !== 3'b101) begin n_err++; $display("FAIL srai_bus: op2 %h f7 %h f3 %h want 4 20 5", op2, funct7, funct3_adder); end
    step();
    n_cmp++; if (rd_wdata !== 32'hF8000000 || rd_we !== 1'b1 || rd_addr !== 5'd4) begin n_err++; $display("FAIL srai_wb: data %h we %b rd %0d want f8000000 1 4", rd_wdata, rd_we, rd_addr); end
    step();
  endtask

  task automatic test_addi();
    rs1_data = 32'b0; rs2_data = 32'h0000_1234;
    send(32'hFFF00293);
    n_cmp++; if (op2 !== 32'hFFFFFFFF || funct7 !== 7'd0) begin n_err++; $display("FAIL addi_bus: op2 %h f7 %h want ffffffff 0", op2, funct7); end
    step();
    n_cmp++; if (rd_wdata !== 32'hFFFFFFFF || rd_we !== 1'b1 || rd_addr !== 5'd5) begin n_err++; $display("FAIL addi_wb: data %h we %b rd %0d want ffffffff 1 5", rd_wdata, rd_we, rd_addr); end
    step();
    send(32'h00100013);
    n_cmp++; if (op2 !== 32'd1 || instr_ready !== 1'b0) begin n_err++; $display("FAIL x0_issue: op2 %h ready %b want 1 0", op2, instr_ready); end
    step();
    n_cmp++; if (rd_we !== 1'b0 || rd_wdata !== 32'd1 || rd_addr !== 5'd0) begin n_err++; $display("FAIL x0_wb: we %b data %h rd %0d want 0 1 0", rd_we, rd_wdata, rd_addr); end
    step();
    n_cmp++; if (rd_we !== 1'b0 || instr_ready !== 1'b1) begin n_err++; $display("FAIL x0_done: we %b ready %b want 0 1", rd_we, instr_ready); end
  endtask

  task automatic test_slt_sub();
    rs1_data = 32'hFFFFFFFF; rs2_data = 32'd1;
    send(32'h0020A3B3);
    step();
    n_cmp++; if (rd_wdata !== 32'd1 || rd_addr !== 5'd7 || rd_we !== 1'b1) begin n_err++; $display("FAIL slt_wb: data %h rd %0d we %b want 1 7 1", rd_wdata, rd_addr, rd_we); end
    step();
    rs1_data = 32'd9; rs2_data = 32'd4;
    send(32'h40208433);
    n_cmp++; if (funct7 !== 7'b0100000 || op1 !== 32'd9) begin n_err++; $display("FAIL sub_bus: f7 %h op1 %h want 20 9", funct7, op1); end
    step();
    n_cmp++; if (rd_wdata !== 32'd5 || rd_addr !== 5'd8) begin n_err++; $display("FAIL sub_wb: data %h rd %0d want 5 8", rd_wdata, rd_addr); end
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] bad [3];
    bad[0] = 32'h0000007F; bad[1] = 32'h4020F1B3; bad[2] = 32'h40109093;
    rs1_data = 32'hDEAD0000; rs2_data = 32'h0000BEEF;
    for (int i = 0; i < 3; i++) begin
      send(bad[i]);
      n_cmp++; if (illegal !== 1'b1 || instr_ready !== 1'b1 || rd_we !== 1'b0) begin n_err++; $display("FAIL ill%0d_pulse: ill %b ready %b we %b want 1 1 0", i, illegal, instr_ready, rd_we); end
      n_cmp++; if (op1 !== 32'd9 || op2 !== 32'd4 || rd_wdata !== 32'd5) begin n_err++; $display("FAIL ill%0d_hold: op1 %h op2 %h data %h want 9 4 5", i, op1, op2, rd_wdata); end
      step();
      n_cmp++; if (illegal !== 1'b0 || rd_we !== 1'b0 || instr_ready !== 1'b1) begin n_err++; $display("FAIL ill%0d_after: ill %b we %b ready %b want 0 0 1", i, illegal, rd_we, instr_ready); end
      step();
      n_cmp++; if (rd_we !== 1'b0) begin n_err++; $display("FAIL ill%0d_nowb: we %b want 0", i, rd_we); end
    end
  endtask

  task automatic test_lui();
    rs1_data = 32'h11111111; rs2_data = 32'h22222222;
    send(32'h12345337);
`ifdef ALU_ISSUE_LUI_EN
    n_cmp++; if (op1 !== 32'b0 || op2 !== 32'h12345000 || funct7 !== 7'd0) begin n_err++; $display("FAIL lui_bus: op1 %h op2 %h f7 %h want 0 12345000 0", op1, op2, funct7); end
    step();
    n_cmp++; if (rd_wdata !== 32'h12345000 || rd_we !== 1'b1 || rd_addr !== 5'd6) begin n_err++; $display("FAIL lui_wb: data %h we %b rd %0d want 12345000 1 6", rd_wdata, rd_we, rd_addr); end
    step();
`else
    n_cmp++; if (illegal !== 1'b1 || instr_ready !== 1'b1) begin n_err++; $display("FAIL lui_ill: ill %b ready %b want 1 1", illegal, instr_ready); end
    step();
    n_cmp++; if (illegal !== 1'b0 || rd_we !== 1'b0) begin n_err++; $display("FAIL lui_after: ill %b we %b want 0 0", illegal, rd_we); end
    step();
    n_cmp++; if (rd_we !== 1'b0) begin n_err++; $display("FAIL lui_nowb: we %b want 0", rd_we); end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    instr = 32'h002081B3; instr_valid = 1'b1; rs1_data = 32'd5; rs2_data = 32'd7;
    step();
    instr = 32'h40208433; rs1_data = 32'd9; rs2_data = 32'd4;
    n_cmp++; if (op1 !== 32'd5 || instr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_e0: op1 %h ready %b want 5 0", op1, instr_ready); end
    step();
    n_cmp++; if (op1 !== 32'd5 || rd_wdata !== 32'd12 || rd_we !== 1'b1) begin n_err++; $display("FAIL b2b_e1: op1 %h data %h we %b want 5 c 1", op1, rd_wdata, rd_we); end
    step();
    n_cmp++; if (op1 !== 32'd5 || instr_ready !== 1'b1 || rd_we !== 1'b0) begin n_err++; $display("FAIL b2b_e2: op1 %h ready %b we %b want 5 1 0", op1, instr_ready, rd_we); end
    step();
    instr_valid = 1'b0;
    n_cmp++; if (op1 !== 32'd9 || funct7 !== 7'b0100000 || instr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_e3: op1 %h f7 %h ready %b want 9 20 0", op1, funct7, instr_ready); end
    step();
    n_cmp++; if (rd_wdata !== 32'd5 || rd_addr !== 5'd8 || rd_we !== 1'b1) begin n_err++; $display("FAIL b2b_e4: data %h rd %0d we %b want 5 8 1", rd_wdata, rd_addr, rd_we); end
    step();
  endtask

  task automatic test_reset_mid_issue();
    rs1_data = 32'd5; rs2_data = 32'd7;
    send(32'h002081B3);
    rst = 1'b1; #1;
    n_cmp++; if (op1 !== 32'b0 || op2 !== 32'b0 || funct7 !== 7'b0 || funct3_adder !== 3'b0 || funct3_comp !== 3'b0) begin n_err++; $display("FAIL mid_rst_bus: op1 %h op2 %h f7 %h f3 %h/%h want all 0", op1, op2, funct7, funct3_adder, funct3_comp); end
    n_cmp++; if (rd_addr !== 5'b0 || rd_wdata !== 32'b0 || rd_we !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_wb: rd %0d data %h we %b ill %b ready %b want 0 0 0 0 0", rd_addr, rd_wdata, rd_we, illegal, instr_ready); end
    step();
    n_cmp++; if (rd_we !== 1'b0 || instr_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold: we %b ready %b want 0 0", rd_we, instr_ready); end
    @(negedge clk); rst = 1'b0;
    step();
    n_cmp++; if (instr_ready !== 1'b1 || rd_we !== 1'b0) begin n_err++; $display("FAIL mid_rst_release: ready %b we %b want 1 0", instr_ready, rd_we); end
    step();
    n_cmp++; if (rd_we !== 1'b0 || rd_wdata !== 32'b0) begin n_err++; $display("FAIL mid_rst_dropped: we %b data %h want 0 0", rd_we, rd_wdata); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_srai();
    test_addi();
    test_slt_sub();
    test_illegal();
    test_lui();
    test_back_to_back();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue sequencer for the single-cycle ALU. Accepts one 32-bit RV32I ALU instruction per valid/ready handshake and drives the register-file read addresses. Registers operands and funct fields onto the ALU input bus, selects the matching ALU result (adder, shifter or comparator) and emits a one-cycle register-file write-back. One instruction is in flight at a time; sits between instruction fetch and the ALU/register file.

## Interface
- No parameters; all widths fixed: XLEN 32, 5-bit register addresses.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr`  in  32  instruction word; sampled when `instr_valid && instr_ready`.
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  block can accept an instruction.
- `rs1_addr`, `rs2_addr`  out  5 each  combinational, `instr[19:15]` and `instr[24:20]`.
- `rs1_data`, `rs2_data`  in  32 each  register-file read data, same cycle as address.
- `op1`, `op2`  out  32 each  registered ALU operands.
- `funct7`  out  7  registered ALU funct7.
- `funct3_adder`, `funct3_comp`  out  3 each  registered, both equal to decoded funct3.
- `adder_rsv`, `shifter_rsv`, `comparator_rsv`  in  32 each  ALU results, combinational from the above.
- `rd_we`  out  1  write-back strobe, one cycle.
- `rd_addr`  out  5  write-back register.
- `rd_wdata`  out  32  write-back data.
- `illegal`  out  1  one-cycle pulse: rejected instruction.

## Operation
- FSM states: IDLE, ISSUE, WB.
  - IDLE: `instr_ready`=1. On handshake, decode, then go to ISSUE if legal, else pulse `illegal` and stay in IDLE.
  - ISSUE: capture selected ALU result into `rd_wdata`, then go to WB.
  - WB: `rd_we`=1 unless rd==0, then go to IDLE.
- R-type (opcode 0110011): op1=rs1_data, op2=rs2_data, funct7=instr[31:25].
  - Legal funct7: 0000000 with any funct3; 0100000 with funct3 000 or 101.
- I-type (opcode 0010011):
  - funct3 001/101: op2={27'b0,instr[24:20]}, funct7=instr[31:25]. Legal: slli needs funct7 0000000; srli/srai need 0000000/0100000.
  - Other funct3: op2=sign-extended instr[31:20], funct7=0000000 (addi never subtracts).
- Result select by funct3: 001/101 → shifter_rsv; 010/011 → comparator_rsv; else adder_rsv. Data passes through unmodified.
- Any other opcode is illegal. No register write occurs; ALU bus outputs keep their previous values.
- rd==0: full sequence runs, `rd_we` stays 0.

## Timing
- Cycle 0: handshake; operands latched at the edge.
- Cycle 1: ALU bus driven (ISSUE).
- Cycle 2: `rd_we` high (WB).
- Cycle 3: `instr_ready` high again.
- Throughput: one instruction per 3 cycles. Write-back always completes before the next register read, so there are no hazards and no forwarding.
- `illegal` is asserted in the cycle after the handshake, while `instr_ready` is already 1 again.
- Reset, including mid-operation: state IDLE; op1, op2, funct7, funct3_*, rd_addr and rd_wdata = 0; rd_we=0; illegal=0. An in-flight instruction is dropped without write-back.
- `instr_ready` is 0 during reset assertion; it rises in the first cycle after deassertion.
- `instr_valid` held high while `instr_ready`=0 has no effect. Upstream must hold `instr` stable until the handshake.

## Configuration
- `ALU_ISSUE_LUI_EN` defined: opcode 0110111 (LUI) is legal.
  - op1=0, op2={instr[31:12],12'b0}, funct3=000, funct7=0000000; result taken from adder_rsv.
- Not defined: LUI is illegal (pulses `illegal`, no write).

## Test plan
- Reset mid-ISSUE: assert `rst` while in ISSUE → all outputs 0 immediately; no `rd_we`; `instr_ready`=1 one cycle after release.
- `add x3,x1,x2` with rs1_data=5, rs2_data=7, ALU model attached → op1=5, op2=7, funct7=0; `rd_we`=1, rd_addr=3, rd_wdata=12 exactly 2 cycles after handshake.
- `srai x4,x1,4` (instr 0x4040D213) with rs1_data=0x80000000 → op2=4, funct7=0100000; rd_wdata=0xF8000000 taken from shifter_rsv.
- `addi x5,x0,-1` → op2=0xFFFFFFFF, funct7=0000000, rd_wdata=0xFFFFFFFF. `addi x0,x0,1` → full sequence runs, `rd_we` never asserts.
- Illegal instructions 0x0000007F, and R-type with funct7 0100000 and funct3 111 → `illegal` pulses 1 cycle, no `rd_we`, `instr_ready` stays 1.
- `lui x6,0x12345` → with `ALU_ISSUE_LUI_EN` defined: rd_wdata=0x12345000. Without it: `illegal` pulse.
